// File: rtl/fifo_pkg.sv
// Shared helpers for the multi-port free-list FIFO: enable-vector bit counting.
package fifo_pkg;

  localparam int MAX_PORTS = 32;

  function automatic int prefix_count(input logic [MAX_PORTS-1:0] bits, input int idx);
    int n;
    n = 0;
    for (int j = 0; j < MAX_PORTS; j++) begin
      if (j < idx && bits[j]) begin
        n = n + 1;
      end
    end
    return n;
  endfunction

  function automatic int popcount(input logic [MAX_PORTS-1:0] bits);
    return prefix_count(bits, MAX_PORTS);
  endfunction

endpackage

// File: rtl/fifo_port_alloc.sv
// Compacts a sparse enable vector: per-port offset among enabled ports plus total count.
module fifo_port_alloc
  import fifo_pkg::*;
#(
  parameter int PORTS = 3,
  parameter int OW    = 7
) (
  input  logic [PORTS-1:0]         en,
  output logic [PORTS-1:0][OW-1:0] offset,
  output logic [OW-1:0]            count
);

  logic [MAX_PORTS-1:0] en_ext;

  assign en_ext = MAX_PORTS'(en);

  // Offsets and total are pure functions of the enable vector.
  always_comb begin
    offset = '0;
    for (int i = 0; i < PORTS; i++) begin
      offset[i] = OW'(prefix_count(en_ext, i));
    end
    count = OW'(popcount(en_ext));
  end

endmodule

// File: rtl/fifo.sv
// Multi-port circular FIFO used as the renamer free list; head entries are read combinationally.
// Optional simulation checks for underflow/overflow are enabled by defining FIFO_CHECK_EN.
module fifo
  import fifo_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = 6,
  parameter int PORTS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(DEPTH):0]        rst_skip,
  input  logic [PORTS-1:0]              get_en,
  input  logic [PORTS-1:0]              put_en,
  input  logic [PORTS-1:0][WIDTH-1:0]   put,
  output logic [PORTS-1:0][WIDTH-1:0]   gotten,
  output logic [$clog2(DEPTH):0]        len
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0]        mem [DEPTH];
  logic [AW-1:0]           head;
  logic [AW-1:0]           tail;
  logic [PORTS-1:0][LW-1:0] gp;
  logic [PORTS-1:0][LW-1:0] pp;
  logic [LW-1:0]           g_cnt;
  logic [LW-1:0]           p_cnt;
  logic [LW-1:0]           g_eff;
  logic [LW-1:0]           p_eff;
  logic [LW-1:0]           space;

  fifo_port_alloc #(.PORTS(PORTS), .OW(LW)) u_get_alloc (
    .en     (get_en),
    .offset (gp),
    .count  (g_cnt)
  );

  fifo_port_alloc #(.PORTS(PORTS), .OW(LW)) u_put_alloc (
    .en     (put_en),
    .offset (pp),
    .count  (p_cnt)
  );

  // Clamp pops to occupancy and pushes to the room left after this cycle's pops.
  always_comb begin
    g_eff = (g_cnt > len) ? len : g_cnt;
    space = LW'(DEPTH) - len + g_eff;
    p_eff = (p_cnt > space) ? space : p_cnt;
  end

  // Enabled ports reaching past the stored entries read as zero; no bypass of same-cycle puts.
  always_comb begin
    gotten = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (get_en[i] && (gp[i] >= len)) begin
        gotten[i] = WIDTH'(0);
      end else begin
        gotten[i] = mem[head + AW'(gp[i])];
      end
    end
  end

  // Storage and pointer update; reset preloads the identity sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= WIDTH'(i);
      end
      head <= rst_skip[AW-1:0];
      tail <= '0;
      len  <= LW'(DEPTH) - rst_skip;
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        if (put_en[i] && (pp[i] < space)) begin
          mem[tail + AW'(pp[i])] <= put[i];
        end
      end
      head <= head + AW'(g_eff);
      tail <= tail + AW'(p_eff);
      len  <= len - g_eff + p_eff;
    end
  end

`ifdef FIFO_CHECK_EN
  longint unsigned cycle;

  // Flags requests the caller should never issue; datapath clamps them regardless.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle <= 64'd0;
    end else begin
      cycle <= cycle + 64'd1;
      if (g_cnt > len) begin
        $error("fifo underflow at cycle %0d: gets=%0d len=%0d", cycle, g_cnt, len);
      end
      if ((int'(len) - int'(g_cnt) + int'(p_cnt)) > DEPTH) begin
        $error("fifo overflow at cycle %0d: len=%0d gets=%0d puts=%0d", cycle, len, g_cnt, p_cnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo.sv
// Directed self-checking bench for the multi-port free-list FIFO (DEPTH=64, WIDTH=6, PORTS=3).
module tb_fifo;

  localparam int DEPTH = 64;
  localparam int WIDTH = 6;
  localparam int PORTS = 3;
  localparam int LW    = 7;

  logic                        clk;
  logic                        rst;
  logic [LW-1:0]               rst_skip;
  logic [PORTS-1:0]            get_en;
  logic [PORTS-1:0]            put_en;
  logic [PORTS-1:0][WIDTH-1:0] put;
  logic [PORTS-1:0][WIDTH-1:0] gotten;
  logic [LW-1:0]               len;

  int checks;
  int errors;
  logic [WIDTH-1:0] q[$];
  int tok;

  fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .PORTS(PORTS)) dut (
    .clk      (clk),
    .rst      (rst),
    .rst_skip (rst_skip),
    .get_en   (get_en),
    .put_en   (put_en),
    .put      (put),
    .gotten   (gotten),
    .len      (len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    rst_skip = 7'd33;
    get_en   = 3'b000;
    put_en   = 3'b000;
    put      = '0;
    tick();
    rst = 1'b0;

    // preload with 33 skipped values
    check("rst_len", 32'(len), 32'd31);
    get_en = 3'b111;
    #1;
    check("rst_g0", 32'(gotten[0]), 32'd33);
    check("rst_g1", 32'(gotten[1]), 32'd34);
    check("rst_g2", 32'(gotten[2]), 32'd35);

    // sparse get: ports 0 and 2
    get_en = 3'b101;
    #1;
    check("sparse_g0", 32'(gotten[0]), 32'd33);
    check("sparse_g2", 32'(gotten[2]), 32'd34);
    tick();
    get_en = 3'b000;
    check("sparse_len", 32'(len), 32'd29);
    get_en = 3'b111;
    #1;
    check("sparse_n0", 32'(gotten[0]), 32'd35);
    check("sparse_n1", 32'(gotten[1]), 32'd36);
    check("sparse_n2", 32'(gotten[2]), 32'd37);

    // get three and put two in the same cycle
    put_en = 3'b011;
    put[0] = 6'd5;
    put[1] = 6'd7;
    put[2] = 6'd63;
    tick();
    get_en = 3'b000;
    put_en = 3'b000;
    check("gp_len", 32'(len), 32'd28);

    // drain, checking order including the two pushed tokens
    for (int v = 38; v < 64; v++) q.push_back(6'(v));
    q.push_back(6'd5);
    q.push_back(6'd7);
    while (q.size() >= 3) begin
      get_en = 3'b111;
      #1;
      for (int i = 0; i < PORTS; i++) check("drain_g", 32'(gotten[i]), 32'(q[i]));
      tick();
      for (int i = 0; i < PORTS; i++) void'(q.pop_front());
      check("drain_len", 32'(len), 32'(q.size()));
    end
    get_en = 3'b001;
    #1;
    check("drain_last", 32'(gotten[0]), 32'd7);
    tick();
    void'(q.pop_front());
    check("drain_empty", 32'(len), 32'd0);

    // empty: get alone underflows to zero, len holds
    get_en = 3'b001;
    #1;
    check("empty_g0", 32'(gotten[0]), 32'd0);
    tick();
    check("empty_len", 32'(len), 32'd0);
    put_en = 3'b001;
    put[0] = 6'd9;
    #1;
    check("empty_nobypass", 32'(gotten[0]), 32'd0);
    tick();
    get_en = 3'b000;
    put_en = 3'b000;
    check("empty_put_len", 32'(len), 32'd1);
    get_en = 3'b111;
    #1;
    check("under_g0", 32'(gotten[0]), 32'd9);
    check("under_g1", 32'(gotten[1]), 32'd0);
    check("under_g2", 32'(gotten[2]), 32'd0);
    get_en = 3'b000;
    q.push_back(6'd9);

    // stream through the index 63 -> 0 boundary with a model queue
    tok = 20;
    put_en = 3'b111;
    for (int i = 0; i < PORTS; i++) begin
      put[i] = 6'(tok + i);
      q.push_back(6'(tok + i));
    end
    tok = tok + 3;
    tick();
    check("wrap_fill_len", 32'(len), 32'd4);
    for (int c = 0; c < 20; c++) begin
      get_en = 3'b111;
      put_en = 3'b111;
      for (int i = 0; i < PORTS; i++) put[i] = 6'(tok + i);
      #1;
      for (int i = 0; i < PORTS; i++) check("wrap_g", 32'(gotten[i]), 32'(q[i]));
      tick();
      for (int i = 0; i < PORTS; i++) void'(q.pop_front());
      for (int i = 0; i < PORTS; i++) q.push_back(6'(tok + i));
      tok = tok + 3;
      check("wrap_len", 32'(len), 32'd4);
    end
    get_en = 3'b111;
    put_en = 3'b000;
    #1;
    for (int i = 0; i < PORTS; i++) check("wrap_tail_g", 32'(gotten[i]), 32'(q[i]));
    get_en = 3'b000;

    // full: puts with no gets are dropped
    rst      = 1'b1;
    rst_skip = 7'd0;
    tick();
    rst = 1'b0;
    check("full_len", 32'(len), 32'd64);
    put_en = 3'b111;
    put[0] = 6'd50;
    put[1] = 6'd51;
    put[2] = 6'd52;
    tick();
    put_en = 3'b000;
    check("full_hold_len", 32'(len), 32'd64);
    get_en = 3'b111;
    #1;
    check("full_g0", 32'(gotten[0]), 32'd0);
    check("full_g1", 32'(gotten[1]), 32'd1);
    check("full_g2", 32'(gotten[2]), 32'd2);
    get_en = 3'b000;

    // rst_skip = DEPTH gives an empty FIFO
    rst      = 1'b1;
    rst_skip = 7'd64;
    tick();
    rst = 1'b0;
    check("skipall_len", 32'(len), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
